// File: rtl/cluster_readout_scheduler_if.sv
// Per-BX count/grant handshake between the cluster counter, the scheduler and the packer.
interface cluster_readout_scheduler_if #(
  parameter int unsigned MXCNTB = 11
);
  logic              cnt_valid_i;
  logic [MXCNTB-1:0] cnt_i;
  logic              grant_valid_o;
  logic [3:0]        grant_n_o;

  modport master (output cnt_valid_i, cnt_i, input grant_valid_o, grant_n_o);
  modport slave  (input cnt_valid_i, cnt_i, output grant_valid_o, grant_n_o);
endinterface

// File: rtl/cluster_readout_scheduler.sv
// Grants up to MAX_PER_BX clusters per BX, carries the excess as a bounded backlog,
// throttles with hysteresis and counts truncation events.
module cluster_readout_scheduler #(
  parameter int unsigned MXCNTB      = 11,
  parameter int unsigned MAX_PER_BX  = 8,
  parameter int unsigned BACKLOG_MAX = 64,
  parameter int unsigned HI_WM       = 48,
  parameter int unsigned LO_WM       = 16,
  parameter int unsigned EVCNTB      = 16
) (
  input  logic                       clock4x,
  input  logic                       reset,
  input  logic                       enable_i,
  input  logic                       evcnt_clr_i,
  cluster_readout_scheduler_if.slave bus,
  output logic [6:0]                 backlog_o,
  output logic                       throttle_o,
  output logic                       truncate_o,
  output logic [1:0]                 state_o,
  output logic [EVCNTB-1:0]          evcnt_o
);

  localparam int unsigned BL_W  = 7;
  localparam int unsigned GN_W  = 4;
  localparam int unsigned TOT_W = ((MXCNTB > BL_W) ? MXCNTB : BL_W) + 1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_THROTTLE = 2'd3
  } state_t;

  state_t              r_state,       w_nxt_state;
  logic [BL_W-1:0]     r_backlog,     w_nxt_backlog;
  logic                r_grant_valid, w_nxt_grant_valid;
  logic [GN_W-1:0]     r_grant_n,     w_nxt_grant_n;
  logic                r_truncate,    w_nxt_truncate;
  logic [EVCNTB-1:0]   r_evcnt,       w_nxt_evcnt;

  logic [TOT_W-1:0]    w_total;
  logic [TOT_W-1:0]    w_grant;
  logic [TOT_W-1:0]    w_rem;
  logic                w_accept;
  logic                w_trunc_hit;

  // State and output registers
  always_ff @(posedge clock4x) begin
    if (reset) begin
      r_state       <= ST_DISABLED;
      r_backlog     <= '0;
      r_grant_valid <= 1'b0;
      r_grant_n     <= '0;
      r_truncate    <= 1'b0;
      r_evcnt       <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_backlog     <= w_nxt_backlog;
      r_grant_valid <= w_nxt_grant_valid;
      r_grant_n     <= w_nxt_grant_n;
      r_truncate    <= w_nxt_truncate;
      r_evcnt       <= w_nxt_evcnt;
    end
  end

  // Grant arithmetic, truncation and next-state decision on the post-update backlog
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_backlog     = r_backlog;
    w_nxt_grant_valid = 1'b0;
    w_nxt_grant_n     = r_grant_n;
    w_nxt_truncate    = 1'b0;
    w_nxt_evcnt       = r_evcnt;

    w_total     = TOT_W'(r_backlog) + TOT_W'(bus.cnt_i);
    w_grant     = (w_total > TOT_W'(MAX_PER_BX)) ? TOT_W'(MAX_PER_BX) : w_total;
    w_rem       = w_total - w_grant;
    w_accept    = enable_i && bus.cnt_valid_i && (r_state != ST_DISABLED);
    w_trunc_hit = w_accept && (w_rem > TOT_W'(BACKLOG_MAX));

    if (w_accept) begin
      w_nxt_grant_valid = 1'b1;
      w_nxt_grant_n     = GN_W'(w_grant);
      w_nxt_backlog     = w_trunc_hit ? BL_W'(BACKLOG_MAX) : BL_W'(w_rem);
      w_nxt_truncate    = w_trunc_hit;
      if (w_trunc_hit && (r_evcnt != '1)) begin
        w_nxt_evcnt = r_evcnt + EVCNTB'(1);
      end
    end

    // Clear beats a coincident truncation
    if (evcnt_clr_i) begin
      w_nxt_evcnt = '0;
    end

    case (r_state)
      ST_DISABLED: w_nxt_state = ST_IDLE;
      ST_IDLE, ST_DRAIN: begin
        if (w_nxt_backlog >= BL_W'(HI_WM))    w_nxt_state = ST_THROTTLE;
        else if (w_nxt_backlog != '0)         w_nxt_state = ST_DRAIN;
        else                                  w_nxt_state = ST_IDLE;
      end
      ST_THROTTLE: begin
        if (w_nxt_backlog == '0)              w_nxt_state = ST_IDLE;
        else if (w_nxt_backlog <= BL_W'(LO_WM)) w_nxt_state = ST_DRAIN;
        else                                  w_nxt_state = ST_THROTTLE;
      end
      default: w_nxt_state = ST_DISABLED;
    endcase

    if (!enable_i) begin
      w_nxt_state   = ST_DISABLED;
      w_nxt_backlog = '0;
    end
  end

  assign bus.grant_valid_o = r_grant_valid;
  assign bus.grant_n_o     = r_grant_n;
  assign backlog_o         = r_backlog;
  assign truncate_o        = r_truncate;
  assign evcnt_o           = r_evcnt;
  assign state_o           = r_state;
  assign throttle_o        = (r_state == ST_THROTTLE);

endmodule

// File: tb/tb_cluster_readout_scheduler.sv
// Bench for cluster_readout_scheduler: default instance plus a 4-bit event-counter
// instance that reaches saturation quickly; both get identical stimulus.
module tb_cluster_readout_scheduler;

  localparam int MAXG = 8;
  localparam int BMAX = 64;
  localparam int HI   = 48;
  localparam int LO   = 16;

  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic        tb_en = 1'b0;
  logic        tb_v = 1'b0;
  logic [10:0] tb_cnt = '0;
  logic        tb_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cluster_readout_scheduler_if #(.MXCNTB(11)) bus_a ();
  cluster_readout_scheduler_if #(.MXCNTB(11)) bus_b ();

  assign bus_a.cnt_valid_i = tb_v;
  assign bus_a.cnt_i       = tb_cnt;
  assign bus_b.cnt_valid_i = tb_v;
  assign bus_b.cnt_i       = tb_cnt;

  logic [6:0]  a_backlog, b_backlog;
  logic        a_thr, b_thr, a_trunc, b_trunc;
  logic [1:0]  a_state, b_state;
  logic [15:0] a_ev;
  logic [3:0]  b_ev;

  cluster_readout_scheduler dut_a (
    .clock4x(clk), .reset(tb_rst), .enable_i(tb_en), .evcnt_clr_i(tb_clr),
    .bus(bus_a), .backlog_o(a_backlog), .throttle_o(a_thr), .truncate_o(a_trunc),
    .state_o(a_state), .evcnt_o(a_ev)
  );

  cluster_readout_scheduler #(.EVCNTB(4)) dut_b (
    .clock4x(clk), .reset(tb_rst), .enable_i(tb_en), .evcnt_clr_i(tb_clr),
    .bus(bus_b), .backlog_o(b_backlog), .throttle_o(b_thr), .truncate_o(b_trunc),
    .state_o(b_state), .evcnt_o(b_ev)
  );

  // Reference model: state numbers follow the documented encoding
  int m_backlog = 0, m_state = 0, m_gv = 0, m_gn = 0, m_trunc = 0, m_ev16 = 0, m_ev4 = 0;

  task automatic model_step();
    int total, g, rem;
    if (tb_rst) begin
      m_backlog = 0; m_state = 0; m_gv = 0; m_gn = 0; m_trunc = 0; m_ev16 = 0; m_ev4 = 0;
      return;
    end
    m_gv = 0;
    m_trunc = 0;
    if (tb_en && tb_v && m_state != 0) begin
      total = m_backlog + int'(tb_cnt);
      g     = (total < MAXG) ? total : MAXG;
      rem   = total - g;
      m_gv  = 1;
      m_gn  = g;
      if (rem > BMAX) begin
        m_backlog = BMAX;
        m_trunc   = 1;
        if (m_ev16 < 65535) m_ev16++;
        if (m_ev4 < 15) m_ev4++;
      end else begin
        m_backlog = rem;
      end
    end
    if (tb_clr) begin
      m_ev16 = 0;
      m_ev4  = 0;
    end
    if (!tb_en) begin
      m_state = 0;
      m_backlog = 0;
    end else if (m_state == 0) m_state = 1;
    else if (m_state == 3) m_state = (m_backlog == 0) ? 1 : (m_backlog <= LO) ? 2 : 3;
    else m_state = (m_backlog >= HI) ? 3 : (m_backlog > 0) ? 2 : 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    chk("a_grant_valid", int'(bus_a.grant_valid_o), m_gv);
    chk("a_grant_n",     int'(bus_a.grant_n_o),     m_gn);
    chk("a_backlog",     int'(a_backlog),           m_backlog);
    chk("a_state",       int'(a_state),             m_state);
    chk("a_throttle",    int'(a_thr),               (m_state == 3) ? 1 : 0);
    chk("a_truncate",    int'(a_trunc),             m_trunc);
    chk("a_evcnt",       int'(a_ev),                m_ev16);
    chk("b_grant_n",     int'(bus_b.grant_n_o),     m_gn);
    chk("b_backlog",     int'(b_backlog),           m_backlog);
    chk("b_state",       int'(b_state),             m_state);
    chk("b_truncate",    int'(b_trunc),             m_trunc);
    chk("b_evcnt",       int'(b_ev),                m_ev4);
  end

  task automatic step(input logic rst, input logic en, input logic v,
                      input int cnt, input logic clr);
    tb_rst = rst;
    tb_en  = en;
    tb_v   = v;
    tb_cnt = 11'(cnt);
    tb_clr = clr;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int gv, input int gn, input int bl,
                     input int st, input int tr);
    chk({name, "_gv"},    int'(bus_a.grant_valid_o), gv);
    if (gn >= 0) chk({name, "_gn"}, int'(bus_a.grant_n_o), gn);
    chk({name, "_bl"},    int'(a_backlog), bl);
    chk({name, "_st"},    int'(a_state), st);
    chk({name, "_thr"},   int'(a_thr), (st == 3) ? 1 : 0);
    chk({name, "_trunc"}, int'(a_trunc), tr);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    lit("reset", 0, 0, 0, 0, 0);
    chk("reset_ev", int'(a_ev), 0);
    step(0, 1, 0, 0, 0);
    lit("enable", 0, 0, 0, 1, 0);

    // Single BX within budget
    step(0, 1, 1, 5, 0);  lit("t1", 1, 5, 0, 1, 0);

    // Backlog drains across empty BXs
    step(0, 1, 1, 20, 0); lit("t2a", 1, 8, 12, 2, 0);
    step(0, 1, 1, 0, 0);  lit("t2b", 1, 8, 4, 2, 0);
    step(0, 1, 1, 0, 0);  lit("t2c", 1, 4, 0, 1, 0);
    step(0, 1, 1, 0, 0);  lit("t2d", 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);  lit("t2idle", 0, 0, 0, 1, 0);

    // Throttle hysteresis
    step(0, 1, 1, 60, 0); lit("t3a", 1, 8, 52, 3, 0);
    step(0, 1, 1, 0, 0);  lit("t3b", 1, 8, 44, 3, 0);
    step(0, 1, 1, 0, 0);  lit("t3c", 1, 8, 36, 3, 0);
    step(0, 1, 1, 0, 0);  lit("t3d", 1, 8, 28, 3, 0);
    step(0, 1, 1, 0, 0);  lit("t3e", 1, 8, 20, 3, 0);
    step(0, 1, 1, 0, 0);  lit("t3f", 1, 8, 12, 2, 0);
    step(0, 1, 1, 0, 0);  lit("t3g", 1, 8, 4, 2, 0);
    step(0, 1, 1, 0, 0);  lit("t3h", 1, 4, 0, 1, 0);

    // Overflow truncation and event-counter saturation
    step(0, 1, 1, 68, 0);  lit("t4a", 1, 8, 60, 3, 0);
    step(0, 1, 1, 100, 0); lit("t4b", 1, 8, 64, 3, 1);
    chk("t4b_ev", int'(a_ev), 1);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 100, 0);
    chk("t4sat_ev16", int'(a_ev), 17);
    chk("t4sat_ev4",  int'(b_ev), 15);
    step(0, 1, 1, 100, 0);
    chk("t4sat_hold", int'(b_ev), 15);

    // Clear coincident with truncation
    step(0, 1, 1, 100, 1); lit("t6", 1, 8, 64, 3, 1);
    chk("t6_ev", int'(a_ev), 0);
    step(0, 1, 0, 0, 0);   lit("t6idle", 0, 8, 64, 3, 0);

    // rem = 65 truncates
    step(0, 1, 1, 9, 0);   lit("rem65", 1, 8, 64, 3, 1);
    chk("rem65_ev", int'(a_ev), 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    lit("lo_exact", 1, 8, 16, 2, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);   lit("drain0", 1, 8, 0, 1, 0);

    // rem = 64 fits exactly
    step(0, 1, 1, 72, 0);  lit("rem64", 1, 8, 64, 3, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 56, 0);  lit("hi_exact", 1, 8, 48, 3, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    chk("hi_drain", int'(a_backlog), 0);

    // Disable coincident with a strobe
    step(0, 1, 1, 38, 0);  lit("t5a", 1, 8, 30, 2, 0);
    step(0, 0, 1, 50, 0);  lit("t5b", 0, -1, 0, 0, 0);
    step(0, 0, 0, 0, 0);   lit("t5c", 0, -1, 0, 0, 0);
    step(0, 1, 0, 0, 0);   lit("t5d", 0, -1, 0, 1, 0);

    // Full-scale count
    step(0, 1, 1, 2047, 0); lit("maxcnt", 1, 8, 64, 3, 1);
    chk("maxcnt_ev", int'(a_ev), 2);

    // Reset during THROTTLE discards the in-flight strobe
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 58, 0);  lit("t7a", 1, 8, 50, 3, 0);
    step(1, 1, 1, 5, 0);   lit("t7b", 0, 0, 0, 0, 0);
    chk("t7b_ev", int'(a_ev), 0);
    step(0, 1, 0, 0, 0);   lit("t7c", 0, 0, 0, 1, 0);
    step(0, 1, 1, 3, 0);   lit("t7d", 1, 3, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
